// File: rtl/cdb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : cdb_arbiter
//  Description : Common data bus arbiter. Three producers (ALU result, load
//                result, store address) each feed a small FIFO. A round-robin
//                scheduler grants one FIFO head per cycle onto a registered
//                broadcast bus for the ROB, RS and LSB.
//                Optional macro CDB_PERF_CNT_EN adds per-source grant counters
//                and a stall counter.
//  Revision    : 1.0  initial release
// ============================================================================
module cdb_arbiter #(
    parameter int ENTRY_W = 4,
    parameter int DEPTH   = 2
) (
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic               rdy_in,
    input  logic               roll_back,
    input  logic               alu_valid,
    output logic               alu_ready,
    input  logic [ENTRY_W-1:0] alu_entry,
    input  logic [31:0]        alu_result,
    input  logic [31:0]        alu_pc,
    input  logic               ld_valid,
    output logic               ld_ready,
    input  logic [ENTRY_W-1:0] ld_entry,
    input  logic [31:0]        ld_result,
    input  logic               st_valid,
    output logic               st_ready,
    input  logic [ENTRY_W-1:0] st_entry,
    output logic               cdb_valid,
    output logic [1:0]         cdb_src,
    output logic [ENTRY_W-1:0] cdb_entry,
    output logic [31:0]        cdb_result,
    output logic [31:0]        cdb_pc
`ifdef CDB_PERF_CNT_EN
    ,
    output logic [31:0]        perf_grant0,
    output logic [31:0]        perf_grant1,
    output logic [31:0]        perf_grant2,
    output logic [31:0]        perf_stall
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [ENTRY_W-1:0] entry;
        logic [31:0]        result;
        logic [31:0]        pc;
    } item_t;

    item_t            mem_q    [3][DEPTH];
    logic [PTR_W-1:0] rd_ptr_q [3];
    logic [PTR_W-1:0] wr_ptr_q [3];
    logic [CNT_W-1:0] cnt_q    [3];
    logic [CNT_W-1:0] cnt_d    [3];
    item_t            push_item[3];

    logic [2:0]         valid_in;
    logic [2:0]         full;
    logic [2:0]         empty;
    logic [2:0]         push;
    logic [2:0]         pop;
    logic               grant_vld;
    logic [1:0]         grant_src;
    logic [1:0]         cand;
    item_t              head;

    logic               cdb_valid_q;
    logic [1:0]         cdb_src_q;
    logic [ENTRY_W-1:0] cdb_entry_q;
    logic [31:0]        cdb_result_q;
    logic [31:0]        cdb_pc_q;
    logic [1:0]         rr_last_q;

    function automatic logic [1:0] next_src(input logic [1:0] s);
        return (s == 2'd2) ? 2'd0 : s + 2'd1;
    endfunction

    // Per-source push payloads, FIFO status and push/pop qualification.
    always_comb begin
        valid_in     = {st_valid, ld_valid, alu_valid};
        push_item[0] = '{entry: alu_entry, result: alu_result, pc: alu_pc};
        push_item[1] = '{entry: ld_entry,  result: ld_result,  pc: 32'd0};
        push_item[2] = '{entry: st_entry,  result: 32'd0,      pc: 32'd0};
        for (int s = 0; s < 3; s++) begin
            full[s]  = (cnt_q[s] == CNT_W'(DEPTH));
            empty[s] = (cnt_q[s] == '0);
            push[s]  = valid_in[s] && !full[s] && rdy_in && !roll_back;
            pop[s]   = rdy_in && !roll_back && grant_vld && (grant_src == 2'(s));
            cnt_d[s] = cnt_q[s] + CNT_W'(push[s]) - CNT_W'(pop[s]);
        end
    end

    // Round-robin search starting one past the last winner.
    always_comb begin
        grant_vld = 1'b0;
        grant_src = 2'd0;
        cand      = rr_last_q;
        for (int k = 0; k < 3; k++) begin
            cand = next_src(cand);
            if (!grant_vld && !empty[cand]) begin
                grant_vld = 1'b1;
                grant_src = cand;
            end
        end
        head = mem_q[grant_src][rd_ptr_q[grant_src]];
    end

    // FIFO storage writes; contents need no reset since counts gate reads.
    always_ff @(posedge clk_in) begin
        for (int s = 0; s < 3; s++) begin
            if (push[s]) begin
                mem_q[s][wr_ptr_q[s]] <= push_item[s];
            end
        end
    end

    // FIFO pointers/counts, broadcast register and round-robin state.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            for (int s = 0; s < 3; s++) begin
                rd_ptr_q[s] <= '0;
                wr_ptr_q[s] <= '0;
                cnt_q[s]    <= '0;
            end
            cdb_valid_q  <= 1'b0;
            cdb_src_q    <= 2'd0;
            cdb_entry_q  <= '0;
            cdb_result_q <= 32'd0;
            cdb_pc_q     <= 32'd0;
            rr_last_q    <= 2'd2;
        end else if (rdy_in) begin
            if (roll_back) begin
                for (int s = 0; s < 3; s++) begin
                    rd_ptr_q[s] <= '0;
                    wr_ptr_q[s] <= '0;
                    cnt_q[s]    <= '0;
                end
                cdb_valid_q <= 1'b0;
                rr_last_q   <= 2'd2;
            end else begin
                for (int s = 0; s < 3; s++) begin
                    if (push[s]) wr_ptr_q[s] <= wr_ptr_q[s] + PTR_W'(1);
                    if (pop[s])  rd_ptr_q[s] <= rd_ptr_q[s] + PTR_W'(1);
                    cnt_q[s] <= cnt_d[s];
                end
                cdb_valid_q <= grant_vld;
                if (grant_vld) begin
                    cdb_src_q    <= grant_src;
                    cdb_entry_q  <= head.entry;
                    cdb_result_q <= head.result;
                    cdb_pc_q     <= head.pc;
                    rr_last_q    <= grant_src;
                end
            end
        end
    end

    assign alu_ready  = !full[0];
    assign ld_ready   = !full[1];
    assign st_ready   = !full[2];
    assign cdb_valid  = cdb_valid_q;
    assign cdb_src    = cdb_src_q;
    assign cdb_entry  = cdb_entry_q;
    assign cdb_result = cdb_result_q;
    assign cdb_pc     = cdb_pc_q;

`ifdef CDB_PERF_CNT_EN
    logic [31:0] perf_grant_q [3];
    logic [31:0] perf_stall_q;

    // Grant and back-pressure statistics; roll_back deliberately leaves them.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            for (int s = 0; s < 3; s++) perf_grant_q[s] <= 32'd0;
            perf_stall_q <= 32'd0;
        end else if (rdy_in) begin
            for (int s = 0; s < 3; s++) begin
                if (pop[s]) perf_grant_q[s] <= perf_grant_q[s] + 32'd1;
            end
            if (|(valid_in & full)) perf_stall_q <= perf_stall_q + 32'd1;
        end
    end

    assign perf_grant0 = perf_grant_q[0];
    assign perf_grant1 = perf_grant_q[1];
    assign perf_grant2 = perf_grant_q[2];
    assign perf_stall  = perf_stall_q;
`endif

endmodule
`default_nettype wire
